// File: rtl/key_debounce_multi.sv
// Multi-channel key debouncer: 2-FF sync, per-channel stability filter and a
// hold FSM producing press / release / long-press / auto-repeat pulses.
module key_debounce_multi #(
   parameter int unsigned N_KEYS       = 4,
   parameter bit          ACTIVE_LOW   = 1'b1,
   parameter int unsigned DEBOUNCE_CYC = 1250000,
   parameter int unsigned LONG_CYC     = 125000000,
   parameter int unsigned REPEAT_CYC   = 25000000,
   parameter int unsigned CNT_W        = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_KEYS-1:0] kin,
   output logic [N_KEYS-1:0] kout,
   output logic [N_KEYS-1:0] pressed,
   output logic [N_KEYS-1:0] press_pulse,
   output logic [N_KEYS-1:0] release_pulse,
   output logic [N_KEYS-1:0] long_pulse,
   output logic [N_KEYS-1:0] repeat_pulse
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HELD = 2'd1;
   localparam logic [1:0] ST_LONG = 2'd2;

   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'((REPEAT_CYC == 0) ? 32'd0 : REPEAT_CYC - 1);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
      return (&x) ? x : x + 1'b1;
   endfunction

   logic [N_KEYS-1:0] sync1, sync2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= {N_KEYS{ACTIVE_LOW}};
         sync2 <= {N_KEYS{ACTIVE_LOW}};
      end else begin
         sync1 <= kin;
         sync2 <= sync1;
      end
   end

   for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
      logic [1:0]       state;
      logic             prs_q, kout_q, pp_q, rp_q, lp_q, ep_q;
      logic [CNT_W-1:0] deb_cnt, hold_cnt, rep_cnt;
      logic             s, acc, acc_press, acc_rel;

      // s is the synchronised pin normalised so that 1 means pressed
      assign s         = sync2[i] ^ ACTIVE_LOW;
      assign acc       = (s != prs_q) && (deb_cnt == DEB_LAST);
      assign acc_press = acc && s;
      assign acc_rel   = acc && !s;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            state    <= ST_IDLE;
            prs_q    <= 1'b0;
            kout_q   <= ACTIVE_LOW;
            pp_q     <= 1'b0;
            rp_q     <= 1'b0;
            lp_q     <= 1'b0;
            ep_q     <= 1'b0;
            deb_cnt  <= '0;
            hold_cnt <= '0;
            rep_cnt  <= '0;
         end else begin
            pp_q <= 1'b0;
            rp_q <= 1'b0;
            lp_q <= 1'b0;
            ep_q <= 1'b0;

            if (s != prs_q) begin
               if (acc) begin
                  prs_q   <= s;
                  kout_q  <= s ^ ACTIVE_LOW;
                  deb_cnt <= '0;
               end else begin
                  deb_cnt <= sat_inc(deb_cnt);
               end
            end else begin
               deb_cnt <= '0;
            end

            // Release wins over a coincident long/repeat event
            case (state)
               ST_IDLE: begin
                  if (acc_press) begin
                     state    <= ST_HELD;
                     pp_q     <= 1'b1;
                     hold_cnt <= '0;
                  end
               end
               ST_HELD: begin
                  if (acc_rel) begin
                     state    <= ST_IDLE;
                     rp_q     <= 1'b1;
                     hold_cnt <= '0;
                     rep_cnt  <= '0;
                  end else if (hold_cnt == LONG_LAST) begin
                     state    <= ST_LONG;
                     lp_q     <= 1'b1;
                     rep_cnt  <= '0;
                     hold_cnt <= sat_inc(hold_cnt);
                  end else begin
                     hold_cnt <= sat_inc(hold_cnt);
                  end
               end
               ST_LONG: begin
                  if (acc_rel) begin
                     state    <= ST_IDLE;
                     rp_q     <= 1'b1;
                     hold_cnt <= '0;
                     rep_cnt  <= '0;
                  end else if (REPEAT_CYC != 0) begin
                     if (rep_cnt == REP_LAST) begin
                        ep_q    <= 1'b1;
                        rep_cnt <= '0;
                     end else begin
                        rep_cnt <= sat_inc(rep_cnt);
                     end
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end

      assign pressed[i]       = prs_q;
      assign kout[i]          = kout_q;
      assign press_pulse[i]   = pp_q;
      assign release_pulse[i] = rp_q;
      assign long_pulse[i]    = lp_q;
      assign repeat_pulse[i]  = ep_q;
   end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Bench for key_debounce_multi: vector table, corner-case sequences and a
// randomized run, all checked against an age/run-length reference model.
module tb_key_debounce_multi;
   localparam int N   = 4;
   localparam int DEB = 8;
   localparam int LNG = 40;
   localparam int REP = 10;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] kin = 4'hF;
   logic [3:0] kout, pressed, press_pulse, release_pulse, long_pulse, repeat_pulse;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   key_debounce_multi #(
      .N_KEYS(N), .ACTIVE_LOW(1'b1), .DEBOUNCE_CYC(DEB),
      .LONG_CYC(LNG), .REPEAT_CYC(REP), .CNT_W(32)
   ) dut (
      .clk(clk), .rst(rst), .kin(kin), .kout(kout), .pressed(pressed),
      .press_pulse(press_pulse), .release_pulse(release_pulse),
      .long_pulse(long_pulse), .repeat_pulse(repeat_pulse)
   );

   always #5 clk = ~clk;

   // Reference model: pin delay line, mismatch run length, and hold age
   logic [3:0]  m_s1, m_s2, m_prs;
   int          m_run[N];
   int          m_age[N];
   logic [23:0] exp_q[$];

   function automatic void model_reset();
      m_s1  = 4'hF;
      m_s2  = 4'hF;
      m_prs = 4'h0;
      for (int i = 0; i < N; i++) begin
         m_run[i] = 0;
         m_age[i] = -1;
      end
      exp_q.delete();
   endfunction

   function automatic void model_edge(input logic [3:0] k);
      logic [3:0] pp, rp, lp, ep;
      logic       s, acc;
      pp = '0; rp = '0; lp = '0; ep = '0;
      for (int i = 0; i < N; i++) begin
         s   = ~m_s2[i];
         acc = 1'b0;
         if (s != m_prs[i]) begin
            m_run[i]++;
            if (m_run[i] == DEB) begin
               acc      = 1'b1;
               m_run[i] = 0;
               m_prs[i] = s;
               if (s) begin pp[i] = 1'b1; m_age[i] = 0; end
               else   begin rp[i] = 1'b1; m_age[i] = -1; end
            end
         end else begin
            m_run[i] = 0;
         end
         if (!acc && m_prs[i]) begin
            m_age[i]++;
            if (m_age[i] == LNG) lp[i] = 1'b1;
            else if (m_age[i] > LNG && (m_age[i] - LNG) % REP == 0) ep[i] = 1'b1;
         end
      end
      m_s2 = m_s1;
      m_s1 = k;
      exp_q.push_back({~m_prs, m_prs, pp, rp, lp, ep});
   endfunction

   task automatic cmp(input string nm, input logic [3:0] got, input logic [3:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
      end
   endtask

   task automatic cmp_int(input string nm, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
      end
   endtask

   task automatic check_now();
      logic [23:0] e;
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL scoreboard_empty cyc=%0d", cyc);
         return;
      end
      e = exp_q.pop_front();
      cmp("kout",    kout,          e[23:20]);
      cmp("pressed", pressed,       e[19:16]);
      cmp("press",   press_pulse,   e[15:12]);
      cmp("release", release_pulse, e[11:8]);
      cmp("long",    long_pulse,    e[7:4]);
      cmp("repeat",  repeat_pulse,  e[3:0]);
   endtask

   task automatic step(input logic [3:0] k);
      kin = k;
      @(posedge clk);
      cyc++;
      model_edge(k);
      @(negedge clk);
      check_now();
   endtask

   typedef struct {
      logic [3:0] kin;
      int         ncyc;
      logic [3:0] e_prs;
      logic [3:0] e_kout;
      logic [3:0] e_pp;
      logic [3:0] e_rp;
   } vec_t;

   vec_t tbl[7];

   initial begin
      int t0;
      int pp_at[$], rp_at[$], lp_at[$], ep_at[$];
      int exp_ep[5];
      logic [3:0] seen, lvl;
      int rem[N];

      tbl[0] = '{4'hF, 12, 4'h0, 4'hF, 4'h0, 4'h0};
      tbl[1] = '{4'hE,  9, 4'h0, 4'hF, 4'h0, 4'h0};
      tbl[2] = '{4'hE,  1, 4'h1, 4'hE, 4'h1, 4'h0};
      tbl[3] = '{4'hE,  5, 4'h1, 4'hE, 4'h0, 4'h0};
      tbl[4] = '{4'hF, 10, 4'h0, 4'hF, 4'h0, 4'h1};
      tbl[5] = '{4'h3, 10, 4'hC, 4'h3, 4'hC, 4'h0};
      tbl[6] = '{4'hF, 10, 4'h0, 4'hF, 4'h0, 4'hC};
      exp_ep = '{60, 70, 80, 90, 100};

      // Reset state
      rst = 1'b1;
      kin = 4'hF;
      model_reset();
      repeat (3) @(negedge clk);
      cmp("rst_kout", kout, 4'hF);
      cmp("rst_pressed", pressed, 4'h0);
      cmp("rst_pulses", press_pulse | release_pulse | long_pulse | repeat_pulse, 4'h0);
      rst = 1'b0;

      // Vector table: clean press/release latency and parallel presses
      for (int r = 0; r < 7; r++) begin
         for (int c = 0; c < tbl[r].ncyc; c++) step(tbl[r].kin);
         cmp("tbl_pressed", pressed, tbl[r].e_prs);
         cmp("tbl_kout", kout, tbl[r].e_kout);
         cmp("tbl_press", press_pulse, tbl[r].e_pp);
         cmp("tbl_release", release_pulse, tbl[r].e_rp);
      end

      // Bounce on key 0: toggling every 3 cycles never qualifies
      seen = '0;
      for (int c = 0; c < 60; c++) begin
         step(((c / 3) % 2 == 0) ? 4'hE : 4'hF);
         seen |= press_pulse | release_pulse | long_pulse | repeat_pulse;
      end
      for (int c = 0; c < 12; c++) begin
         step(4'hF);
         seen |= press_pulse | release_pulse | long_pulse | repeat_pulse;
      end
      cmp("bounce_pulses", seen, 4'h0);
      cmp("bounce_kout", kout, 4'hF);

      // Long press and auto-repeat on key 1, then release
      t0 = cyc;
      for (int c = 0; c < 115; c++) begin
         step((c < 100) ? 4'hD : 4'hF);
         if (press_pulse[1])   pp_at.push_back(cyc - t0);
         if (release_pulse[1]) rp_at.push_back(cyc - t0);
         if (long_pulse[1])    lp_at.push_back(cyc - t0);
         if (repeat_pulse[1])  ep_at.push_back(cyc - t0);
      end
      cmp_int("lr_press_n", pp_at.size(), 1);
      if (pp_at.size() > 0) cmp_int("lr_press_at", pp_at[0], 10);
      cmp_int("lr_long_n", lp_at.size(), 1);
      if (lp_at.size() > 0) cmp_int("lr_long_at", lp_at[0], 50);
      cmp_int("lr_repeat_n", ep_at.size(), 5);
      for (int i = 0; i < 5; i++)
         if (i < ep_at.size()) cmp_int("lr_repeat_at", ep_at[i], exp_ep[i]);
      cmp_int("lr_release_n", rp_at.size(), 1);
      if (rp_at.size() > 0) cmp_int("lr_release_at", rp_at[0], 110);

      // Reset while key 1 is in the long-hold phase
      for (int c = 0; c < 60; c++) step(4'hD);
      #2 rst = 1'b1;
      #1;
      cmp("rmh_pressed", pressed, 4'h0);
      cmp("rmh_kout", kout, 4'hF);
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      pp_at.delete();
      rp_at.delete();
      t0 = cyc;
      for (int c = 0; c < 12; c++) begin
         step(4'hD);
         if (press_pulse[1])   pp_at.push_back(cyc - t0);
         if (release_pulse[1]) rp_at.push_back(cyc - t0);
      end
      cmp_int("rmh_press_n", pp_at.size(), 1);
      if (pp_at.size() > 0) cmp_int("rmh_press_at", pp_at[0], 10);
      cmp_int("rmh_release_n", rp_at.size(), 0);
      for (int c = 0; c < 12; c++) step(4'hF);

      // Randomized per-channel hold/bounce durations
      lvl = 4'hF;
      for (int i = 0; i < N; i++) rem[i] = $urandom_range(1, 5);
      for (int c = 0; c < 1200; c++) begin
         for (int i = 0; i < N; i++) begin
            if (rem[i] == 0) begin
               lvl[i] = ~lvl[i];
               rem[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(40, 90) : $urandom_range(1, 12);
            end
            rem[i]--;
         end
         step(lvl);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
